// File: rtl/cpu_pkg.sv
// Shared definitions for the register-transfer CPU control path.
// Holds the opcode constants, the ALU operation codes (the ALU uses the
// same encoding), the sequencer state enumeration, the IR field bit
// positions and small opcode-class helpers used by the decoder.
package cpu_pkg;

    // IR field positions
    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation select codes
    localparam logic [3:0] ALU_IDLE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SHR  = 4'b0101;
    localparam logic [3:0] ALU_SHL  = 4'b0110;
    localparam logic [3:0] ALU_ROR  = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_ROL  = 4'b1010;
    localparam logic [3:0] ALU_NEG  = 4'b1011;
    localparam logic [3:0] ALU_NOT  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1110;
    localparam logic [3:0] ALU_DIV  = 4'b1111;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    // ALU function for an opcode; ALU_IDLE means "not an ALU instruction".
    function automatic logic [3:0] alu_sel(input logic [4:0] op);
        case (op)
            OP_ADD:  alu_sel = ALU_ADD;
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            OP_SHR:  alu_sel = ALU_SHR;
            OP_SHL:  alu_sel = ALU_SHL;
            OP_ROR:  alu_sel = ALU_ROR;
            OP_ROL:  alu_sel = ALU_ROL;
            OP_MUL:  alu_sel = ALU_MUL;
            OP_DIV:  alu_sel = ALU_DIV;
            OP_NEG:  alu_sel = ALU_NEG;
            OP_NOT:  alu_sel = ALU_NOT;
            default: alu_sel = ALU_IDLE;
        endcase
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        is_unary = (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/reg_select.sv
// 4-bit register index to 16-bit one-hot decoder with enable.
// Ports:
//   en      in   drive the one-hot output; all-zero when low
//   idx     in   register number R0..R15
//   onehot  out  one-hot select for R0..R15
module reg_select (
    input  logic        en,
    input  logic [3:0]  idx,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = 16'h0000;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the 32-bit register-transfer datapath.
// Fetches via PC/MAR/MDR/IR (T0-T2) and executes register-to-register ALU
// instructions (T3-T5, plus T6 for the HI half of mul/div). Outputs are
// Moore-decoded from the state and the IR fields.
// Ports:
//   Clock, clear          clock, asynchronous active-high reset
//   ir                    current IR contents
//   PCout..MDRout         bus drivers
//   MARin..LOin           register load / control strobes
//   reg_out, reg_in       one-hot R0..R15 bus drive / load enable
//   operation             ALU function select, non-zero only in T4
//   run                   high while sequencing (not RESET/HALT)
//   instr_count           completed instructions, wraps
module control_unit
    import cpu_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                IncPC,
    output logic                Read,
    output logic                Zin_low,
    output logic                Zin_high,
    output logic                HIin,
    output logic                LOin,
    output logic [15:0]         reg_out,
    output logic [15:0]         reg_in,
    output logic [ALU_OP_W-1:0] operation,
    output logic                run,
    output logic [15:0]         instr_count
);

    state_t     state, state_next;
    logic       count_en;
    logic       rout_en, rin_en;
    logic [3:0] rout_idx;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       unused_ir;

    assign opcode    = ir[IR_OP_HI:IR_OP_LO];
    assign ra        = ir[IR_RA_HI:IR_RA_LO];
    assign rb        = ir[IR_RB_HI:IR_RB_LO];
    assign rc        = ir[IR_RC_HI:IR_RC_LO];
    assign unused_ir = ^ir[IR_RC_LO-1:0];

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state       <= S_RESET;
            instr_count <= 16'h0000;
        end else begin
            state <= state_next;
            if (count_en) instr_count <= instr_count + 16'h0001;
        end
    end

    always_comb begin
        state_next = state;
        count_en   = 1'b0;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Zin_low    = 1'b0;
        Zin_high   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        rout_en    = 1'b0;
        rin_en     = 1'b0;
        rout_idx   = rb;
        operation  = '0;
        case (state)
            S_RESET: state_next = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_next = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                if (alu_sel(opcode) != ALU_IDLE) begin
                    state_next = S_T3;
                end else if (opcode == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    // nop and unrecognised opcodes retire straight from fetch
                    state_next = S_T0;
                    count_en   = 1'b1;
                end
            end
            S_T3: begin
                rout_en = 1'b1; rout_idx = rb; Yin = 1'b1;
                state_next = S_T4;
            end
            S_T4: begin
                operation = ALU_OP_W'(alu_sel(opcode));
                Zin_low   = 1'b1;
                Zin_high  = is_muldiv(opcode);
                rout_en   = 1'b1;
                // unary ops take their single operand from Rb again
                rout_idx  = is_unary(opcode) ? rb : rc;
                state_next = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv(opcode)) begin
                    LOin       = 1'b1;
                    state_next = S_T6;
                end else begin
                    rin_en     = 1'b1;
                    state_next = S_T0;
                    count_en   = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
                state_next = S_T0;
                count_en   = 1'b1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    assign run = (state != S_RESET) && (state != S_HALT);

    reg_select u_sel_out (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (reg_out)
    );

    reg_select u_sel_in (
        .en     (rin_en),
        .idx    (ra),
        .onehot (reg_in)
    );

endmodule
